// File: rtl/fc_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_write_sequencer
// Brief    : FCWRTEN latch, gap, then full-chain FC shift closed by WRTFC.
//            Optional FC_START_ON_RESET_EN: auto-write FC_DEFAULT after reset.
// Revision : 1.0
// ============================================================================
module fc_write_sequencer #(
    parameter int                 FC_BITS     = 48,
    parameter int                 NB_DRIVERS  = 2,
    parameter int                 SCLK_DIV    = 2,
    parameter int                 FCWRTEN_LAT = 15,
    parameter int                 WRTFC_LAT   = 5,
    parameter logic [FC_BITS-1:0] FC_DEFAULT  = '0
) (
    input  logic               clk,
    input  logic               rst,      // asynchronous, active-low
    input  logic               start,
    input  logic [FC_BITS-1:0] fc_data,
    output logic               busy,
    output logic               done,
    output logic               FC_en,
    output logic               fc_SCLK,
    output logic               fc_SIN,
    output logic               fc_LAT
);

    localparam int c_N    = FC_BITS * NB_DRIVERS;
    localparam int c_PMAX = (FCWRTEN_LAT > c_N) ? FCWRTEN_LAT : c_N;
    localparam int c_PW   = $clog2(c_PMAX + 1);
    localparam int c_DW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int c_BW   = (FC_BITS > 1) ? $clog2(FC_BITS) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST   = c_DW'(SCLK_DIV - 1);
    localparam logic [c_PW-1:0] c_FCW_LAST   = c_PW'(FCWRTEN_LAT - 1);
    localparam logic [c_PW-1:0] c_SHIFT_LAST = c_PW'(c_N - 1);
    localparam logic [c_PW-1:0] c_LAT_PREV   = c_PW'(c_N - WRTFC_LAT - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(FC_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FCWRTEN = 3'd1,
        S_GAP     = 3'd2,
        S_SHIFT   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_DW-1:0]    r_div;
    logic [c_PW-1:0]    r_per;
    logic [c_BW-1:0]    r_bit;
    logic [FC_BITS-1:0] r_shift;
    logic [FC_BITS-1:0] r_word;
    logic               r_busy;
    logic               r_done;
    logic               r_sclk;
    logic               r_sin;
    logic               r_lat;

    logic               w_start;
    logic [FC_BITS-1:0] w_load;

`ifdef FC_START_ON_RESET_EN
    // Set while in reset, so the first edge after release acts as a start.
    logic r_auto;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_auto <= 1'b1;
        else      r_auto <= 1'b0;
    end

    assign w_start = start | r_auto;
    assign w_load  = r_auto ? FC_DEFAULT : fc_data;
`else
    logic w_unused_fc_default;
    assign w_unused_fc_default = ^FC_DEFAULT;
    assign w_start = start;
    assign w_load  = fc_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_per   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sin   <= 1'b0;
            r_lat   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_FCWRTEN;
                        r_shift <= w_load;
                        r_word  <= w_load;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_per   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b0;
                        r_sin   <= 1'b0;
                        r_lat   <= 1'b1;
                    end
                end
                S_FCWRTEN, S_GAP, S_SHIFT: begin
                    if (r_div != c_DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else if (!r_sclk) begin
                        r_div  <= '0;
                        r_sclk <= 1'b1;
                    end else begin
                        // End of an SCLK period: SIN/LAT for the next one are set here.
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        case (r_state)
                            S_FCWRTEN: begin
                                if (r_per == c_FCW_LAST) begin
                                    r_state <= S_GAP;
                                    r_per   <= '0;
                                    r_lat   <= 1'b0;
                                end else begin
                                    r_per <= r_per + 1'b1;
                                end
                            end
                            S_GAP: begin
                                r_state <= S_SHIFT;
                                r_per   <= '0;
                                r_bit   <= '0;
                                r_sin   <= r_shift[FC_BITS-1];
                                r_lat   <= 1'b0;
                            end
                            default: begin
                                if (r_per == c_SHIFT_LAST) begin
                                    r_state <= S_DONE;
                                    r_per   <= '0;
                                    r_sin   <= 1'b0;
                                    r_lat   <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_per <= r_per + 1'b1;
                                    r_lat <= (r_per >= c_LAT_PREV);
                                    if (r_bit == c_BIT_LAST) begin
                                        r_bit   <= '0;
                                        r_shift <= r_word;
                                        r_sin   <= r_word[FC_BITS-1];
                                    end else begin
                                        r_bit   <= r_bit + 1'b1;
                                        r_shift <= {r_shift[FC_BITS-2:0], 1'b0};
                                        r_sin   <= r_shift[FC_BITS-2];
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_sin   <= 1'b0;
                    r_lat   <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign FC_en   = r_busy;
    assign done    = r_done;
    assign fc_SCLK = r_sclk;
    assign fc_SIN  = r_sin;
    assign fc_LAT  = r_lat;

endmodule
`default_nettype wire
